coeff_block_assembler: RTL and testbench
========================================

Name: coeff_block_assembler

Overview:
Parametrised run/level-to-block assembler for the JPEG decode path. It sits between the Huffman/VLI decoder and the dequant/IDCT stage. It expands (run, value) symbols into full coefficient blocks, handling DC, AC, ZRL and EOB, with optional de-zigzag on write. Two ping-pong banks let one block fill while the previous block waits on a valid/ready output handshake.

Parameters:
COEF_W, 12, signed coefficient width
RUN_W, 4, run field width; ZRL run = 2**RUN_W-1
BLOCK_SIZE, 64, coefficients per block
ZIGZAG, 1, 1 = scan index k stored at natural index ZZ[k]; legal only with BLOCK_SIZE=64 (elaboration error otherwise)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  symbol present
in_ready  out  1  symbol accepted when in_valid && in_ready
in_ac  in  1  0 = DC symbol, 1 = AC symbol
in_run  in  RUN_W  zero run preceding value (AC only)
in_value  in  COEF_W  signed coefficient
out_valid  out  1  completed block available
out_ready  in  1  consumer accepts block
out_data  out  BLOCK_SIZE*COEF_W  block, coefficient i at bits [i*COEF_W +: COEF_W], natural order
out_err  out  1  block closed on a protocol/overflow error
blocks_done  out  16  count of blocks handed off, wraps at 2**16

Behaviour:
- State: two banks with full flags and err bits; fill pointer fb; drain pointer db; position pos (0..BLOCK_SIZE). Banks reset to all-zero.
- Reset: in_ready=1, out_valid=0, out_err=0, out_data=0, blocks_done=0, pos=0, fb=db=0, both banks empty and zeroed.
- in_ready = !full[fb]. A symbol is consumed only on handshake.
- DC (in_ac=0), pos==0:
  - write value at index 0; pos=1.
- DC, pos!=0:
  - value dropped; err[fb]=1; block closed as below.
- AC, run==0, value==0 (EOB):
  - block closed, no write.
- AC, run==2**RUN_W-1, value==0 (ZRL):
  - pos += 2**RUN_W.
  - If the new pos == BLOCK_SIZE: block closed, no err.
  - If the new pos > BLOCK_SIZE: block closed, err=1.
- Other AC, t = pos+run:
  - t < BLOCK_SIZE: write value at index t (mapped through ZZ if ZIGZAG); pos = t+1.
  - pos reaching BLOCK_SIZE closes the block, no err.
  - t >= BLOCK_SIZE: write dropped; err=1; block closed.
- Widths: pos and t are computed at clog2(BLOCK_SIZE)+RUN_W+1 bits, so there is no wrap. Coefficients are stored unmodified.
- Close: on the handshake cycle, full[fb] <= 1, fb toggles, pos <= 0. The next symbol goes to the other bank, or stalls if that bank is full.
- Output:
  - out_valid = full[db]; out_data and out_err come from bank db.
  - Registered: a block closing on cycle N shows out_valid=1 on cycle N+1 at the earliest.
  - While out_valid && !out_ready, out_data and out_err hold stable.
- Drain: on out_valid && out_ready:
  - bank db is zeroed, full[db]=0, err[db]=0, db toggles, blocks_done += 1.
  - The freed bank is writable the following cycle. The same cycle's in_ready still reflects the old state, so there is no combinational ready path.
- Simultaneous close and drain (different banks): both take effect. Sustained throughput is 1 symbol/cycle with out_ready held high.
- Both banks full: in_ready=0 until a drain.
- rst mid-block or mid-stall: all state returns to reset values; the partial block is discarded.
- pos>0 with no further symbols: the block stays open indefinitely. There is no timeout.

Test Plan:
- DC=+5, AC(run0,-3), AC(run2,7), EOB with out_ready=1 -> one block; idx0=5, ZZ[1]=-3, ZZ[4]=7, others 0; out_err=0; blocks_done=1.
- DC=0 followed by EOB -> block of all zeros, out_valid; confirms DC zero is not treated as EOB.
- DC=1, then 3 ZRL, then AC(run14,9) -> 9 at ZZ[63]; block auto-closes with no EOB; out_err=0.
- DC=1, AC(run15,2) x4 -> fourth symbol t=64 is dropped; out_err=1; the following DC starts a clean block in the other bank.
- out_ready=0 while 3 complete blocks are sent -> 2 blocks buffered, in_ready=0 during the 3rd; out_data stable; on release blocks arrive in order and the 3rd completes.
- rst asserted with pos=10 and one full bank -> next cycle out_valid=0, in_ready=1, blocks_done=0; a new block assembles correctly.

Source files
------------

// File: rtl/coeff_block_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : coeff_block_assembler_if
// Brief    : Symbol input and block output bundle of the coefficient assembler.
// Revision : 1.0 - initial release
// ============================================================================
interface coeff_block_assembler_if #(
  parameter int COEF_W     = 12,
  parameter int RUN_W      = 4,
  parameter int BLOCK_SIZE = 64
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_ac;
  logic [RUN_W-1:0]             in_run;
  logic signed [COEF_W-1:0]     in_value;
  logic                         out_valid;
  logic                         out_ready;
  logic [BLOCK_SIZE*COEF_W-1:0] out_data;
  logic                         out_err;
  logic [15:0]                  blocks_done;

  // master: symbol producer / block consumer side
  modport master (
    output in_valid, in_ac, in_run, in_value, out_ready,
    input  in_ready, out_valid, out_data, out_err, blocks_done
  );

  modport slave (
    input  in_valid, in_ac, in_run, in_value, out_ready,
    output in_ready, out_valid, out_data, out_err, blocks_done
  );
endinterface
`default_nettype wire

// File: rtl/coeff_block_assembler.sv
`default_nettype none
// ============================================================================
// Module   : coeff_block_assembler
// Brief    : Expands (run, value) symbols into ping-pong coefficient blocks.
// Revision : 1.0 - initial release
// ============================================================================
module coeff_block_assembler #(
  parameter int COEF_W     = 12,
  parameter int RUN_W      = 4,
  parameter int BLOCK_SIZE = 64,
  parameter int ZIGZAG     = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  coeff_block_assembler_if.slave bus
);

  localparam int               c_iw       = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int               c_pw       = $clog2(BLOCK_SIZE) + RUN_W + 1;
  localparam int               c_dw       = BLOCK_SIZE * COEF_W;
  localparam logic [RUN_W-1:0] c_zrl_run  = '1;
  localparam logic [c_pw-1:0]  c_bs       = c_pw'(BLOCK_SIZE);
  localparam logic [c_pw-1:0]  c_zrl_step = c_pw'(2 ** RUN_W);

  logic [c_dw-1:0] r_bank [2];
  logic [1:0]      r_full;
  logic [1:0]      r_err;
  logic            r_fb;
  logic            r_db;
  logic [c_pw-1:0] r_pos;
  logic [15:0]     r_done;

  logic [c_pw-1:0] w_t;
  logic [c_pw-1:0] w_zrl_pos;
  logic [c_pw-1:0] w_pos_nxt;
  logic [c_iw-1:0] w_idx;
  logic            w_wr;
  logic            w_close;
  logic            w_err;
  logic            w_acc;
  logic            w_drain;

  if (ZIGZAG != 0 && BLOCK_SIZE != 64) begin : g_bad_zigzag
    $error("coeff_block_assembler: ZIGZAG requires BLOCK_SIZE == 64");
  end

  if (ZIGZAG != 0) begin : g_zz
    // Natural (row-major) index for each zig-zag scan position
    localparam logic [5:0] c_zz [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    assign w_idx = c_iw'(c_zz[w_t[5:0]]);
  end else begin : g_nat
    assign w_idx = w_t[c_iw-1:0];
  end

  assign w_t       = bus.in_ac ? (r_pos + c_pw'(bus.in_run)) : '0;
  assign w_zrl_pos = r_pos + c_zrl_step;
  assign w_acc     = bus.in_valid && !r_full[r_fb];
  assign w_drain   = r_full[r_db] && bus.out_ready;

  always_comb begin
    w_wr      = 1'b0;
    w_close   = 1'b0;
    w_err     = 1'b0;
    w_pos_nxt = r_pos;
    if (!bus.in_ac) begin
      if (r_pos == '0) begin
        w_wr      = 1'b1;
        w_pos_nxt = c_pw'(1);
      end else begin
        w_err   = 1'b1;
        w_close = 1'b1;
      end
    end else if (bus.in_value == '0 && bus.in_run == '0) begin
      w_close = 1'b1;
    end else if (bus.in_value == '0 && bus.in_run == c_zrl_run) begin
      w_pos_nxt = w_zrl_pos;
      w_close   = (w_zrl_pos >= c_bs);
      w_err     = (w_zrl_pos > c_bs);
    end else if (w_t < c_bs) begin
      w_wr      = 1'b1;
      w_pos_nxt = w_t + 1'b1;
    end else begin
      w_err   = 1'b1;
      w_close = 1'b1;
    end
    if (w_wr && w_pos_nxt == c_bs) begin
      w_close = 1'b1;
    end
  end

  // Fill and drain always target different banks, so both may act in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_full    <= '0;
      r_err     <= '0;
      r_fb      <= 1'b0;
      r_db      <= 1'b0;
      r_pos     <= '0;
      r_done    <= '0;
    end else begin
      if (w_acc) begin
        if (w_wr) begin
          r_bank[r_fb][w_idx*COEF_W +: COEF_W] <= bus.in_value;
        end
        if (w_err) begin
          r_err[r_fb] <= 1'b1;
        end
        if (w_close) begin
          r_full[r_fb] <= 1'b1;
          r_fb         <= ~r_fb;
          r_pos        <= '0;
        end else begin
          r_pos <= w_pos_nxt;
        end
      end
      if (w_drain) begin
        r_bank[r_db] <= '0;
        r_full[r_db] <= 1'b0;
        r_err[r_db]  <= 1'b0;
        r_db         <= ~r_db;
        r_done       <= r_done + 16'd1;
      end
    end
  end

  assign bus.in_ready    = !r_full[r_fb];
  assign bus.out_valid   = r_full[r_db];
  assign bus.out_data    = r_bank[r_db];
  assign bus.out_err     = r_err[r_db];
  assign bus.blocks_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_coeff_block_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_coeff_block_assembler
// Brief    : Directed vector bench for coeff_block_assembler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coeff_block_assembler;

  localparam int COEF_W = 12;
  localparam int RUN_W  = 4;
  localparam int BS     = 64;
  localparam int DW     = BS * COEF_W;

  typedef struct packed {
    logic               ac;
    logic [3:0]         run;
    logic signed [11:0] val;
    logic               close;
    logic               err;
    logic [2:0]         n;
    logic [5:0]         i0, i1, i2, i3;
    logic signed [11:0] v0, v1, v2, v3;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_done = 0;
  vec_t tbl [32];
  int   ntbl = 0;
  int   nblk = 0;
  logic [COEF_W-1:0] q [$];

  coeff_block_assembler_if #(.COEF_W(COEF_W), .RUN_W(RUN_W), .BLOCK_SIZE(BS)) bus ();

  coeff_block_assembler #(
    .COEF_W(COEF_W), .RUN_W(RUN_W), .BLOCK_SIZE(BS), .ZIGZAG(1)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Blocks handed off are logged by their DC coefficient
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) q.push_back(bus.out_data[COEF_W-1:0]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t s(input logic ac, input int run, input int val);
    vec_t v = '0;
    v.ac  = ac;
    v.run = run[3:0];
    v.val = val[11:0];
    return v;
  endfunction

  function automatic vec_t c(input logic ac, input int run, input int val, input logic err,
                             input int n, input int i0, input int v0, input int i1, input int v1,
                             input int i2, input int v2, input int i3, input int v3);
    vec_t v = s(ac, run, val);
    v.close = 1'b1;
    v.err   = err;
    v.n     = n[2:0];
    v.i0 = i0[5:0]; v.v0 = v0[11:0];
    v.i1 = i1[5:0]; v.v1 = v1[11:0];
    v.i2 = i2[5:0]; v.v2 = v2[11:0];
    v.i3 = i3[5:0]; v.v3 = v3[11:0];
    return v;
  endfunction

  function automatic logic [DW-1:0] expblk(input vec_t v);
    logic [DW-1:0] b = '0;
    if (v.n > 0) b[v.i0*COEF_W +: COEF_W] = v.v0;
    if (v.n > 1) b[v.i1*COEF_W +: COEF_W] = v.v1;
    if (v.n > 2) b[v.i2*COEF_W +: COEF_W] = v.v2;
    if (v.n > 3) b[v.i3*COEF_W +: COEF_W] = v.v3;
    return b;
  endfunction

  task automatic add(input vec_t v);
    tbl[ntbl] = v;
    ntbl++;
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send(input logic ac, input int run, input int val);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_ac    = ac;
    bus.in_run   = run[3:0];
    bus.in_value = val[11:0];
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout got=%0d exp=1", ok);
    end
  endtask

  task automatic drain_one(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    chk({tag, "_blocks_done"}, bus.blocks_done, exp_done);
    chk({tag, "_valid_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] b11;
    int            exp_q [3];
    bus.in_valid  = 1'b0;
    bus.in_ac     = 1'b0;
    bus.in_run    = '0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;

    // A: DC, AC, AC, EOB
    add(s(0, 0, 5)); add(s(1, 0, -3)); add(s(1, 2, 7));
    add(c(1, 0, 0, 0, 3, 0, 5, 1, -3, 9, 7, 0, 0));
    // B: DC zero is data, EOB closes
    add(s(0, 0, 0)); add(c(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // C: ZRL x3 then last position, auto close
    add(s(0, 0, 1)); add(s(1, 15, 0)); add(s(1, 15, 0)); add(s(1, 15, 0));
    add(c(1, 14, 9, 0, 2, 0, 1, 63, 9, 0, 0, 0, 0));
    // D: t=64 overflow on the fourth run-15 AC
    add(s(0, 0, 1)); add(s(1, 15, 2)); add(s(1, 15, 2)); add(s(1, 15, 2));
    add(c(1, 15, 2, 1, 4, 0, 1, 12, 2, 35, 2, 58, 2));
    // E: clean block after the error
    add(s(0, 0, -7)); add(c(1, 0, 0, 0, 1, 0, -7, 0, 0, 0, 0, 0, 0));
    // F: second DC is an error, its value dropped
    add(s(0, 0, 3)); add(c(0, 0, 4, 1, 1, 0, 3, 0, 0, 0, 0, 0, 0));
    // G: ZRL past the end
    add(s(0, 0, 1)); add(s(1, 15, 0)); add(s(1, 15, 0)); add(s(1, 15, 0));
    add(c(1, 15, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    // H: ZRL landing exactly on the end
    add(s(1, 15, 0)); add(s(1, 15, 0)); add(s(1, 15, 0));
    add(c(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_blocks_done", bus.blocks_done, 16'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < ntbl; k++) begin
      send(tbl[k].ac, int'(tbl[k].run), int'(tbl[k].val));
      @(negedge clk);
      chk($sformatf("v%0d_valid", k), bus.out_valid, tbl[k].close);
      if (tbl[k].close) begin
        chk($sformatf("blk%0d_err", nblk), bus.out_err, tbl[k].err);
        chk($sformatf("blk%0d_data", nblk), bus.out_data, expblk(tbl[k]));
        drain_one($sformatf("blk%0d", nblk));
        nblk++;
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: two blocks buffered, third stalls until release
    q.delete();
    b11 = '0;
    b11[COEF_W-1:0] = 12'd11;
    send(0, 0, 11); send(1, 0, 0); send(0, 0, 22); send(1, 0, 0);
    @(negedge clk);
    chk("bp_in_ready_full", bus.in_ready, 1'b0);
    chk("bp_out_valid", bus.out_valid, 1'b1);
    chk("bp_data_first", bus.out_data, b11);
    @(posedge clk);
    #1;
    fork
      send(0, 0, 33);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk($sformatf("bp_stall%0d_ready", i), bus.in_ready, 1'b0);
          chk($sformatf("bp_stall%0d_data", i), bus.out_data, b11);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    send(1, 0, 0);
    repeat (4) @(negedge clk);
    exp_q = '{11, 22, 33};
    exp_done += 3;
    chk("bp_count", q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_order%0d", i), (i < q.size()) ? q[i] : '1, exp_q[i]);
    end
    chk("bp_blocks_done", bus.blocks_done, exp_done);
    chk("bp_drained", bus.out_valid, 1'b0);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;

    // Reset with one full bank and a partial block at pos 10
    send(0, 0, 1); send(1, 0, 0); send(0, 0, 2); send(1, 8, 4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_done = 0;
    @(negedge clk);
    chk("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_in_ready", bus.in_ready, 1'b1);
    chk("mrst_blocks_done", bus.blocks_done, 16'd0);
    chk("mrst_out_data", bus.out_data, '0);
    @(posedge clk);
    #1;
    send(0, 0, 9); send(1, 0, 1); send(1, 0, 0);
    @(negedge clk);
    chk("post_valid", bus.out_valid, 1'b1);
    chk("post_err", bus.out_err, 1'b0);
    chk("post_data", bus.out_data, expblk(c(1, 0, 0, 0, 2, 0, 9, 1, 1, 0, 0, 0, 0)));
    drain_one("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
